// File: rtl/masked_dual_port_ram_clear.sv
// Simple dual-port RAM (one write port, one read port) on a single clock.
// Adds a per-bit write mask, an optional output register, selectable
// read-during-write behaviour and a clear engine that sweeps every word
// with CLEAR_VALUE. The user ports are ignored while a sweep is running.
module masked_dual_port_ram_clear #(
    parameter int                    DATA_WIDTH     = 7,
    parameter int                    ADDR_WIDTH     = 9,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0,
    parameter int                    OUT_REG        = 0,
    parameter int                    BYPASS         = 1,
    parameter int                    CLEAR_ON_RESET = 1
) (
    input  logic                  clock_i,
    input  logic                  reset_n_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] write_addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [DATA_WIDTH-1:0] wmask_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] read_addr_i,
    output logic [DATA_WIDTH-1:0] q_o,
    output logic                  q_valid_o,
    input  logic                  clear_i,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_DONE
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_cnt;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_armed;     // high until the first cycle after reset release

    logic                    w_start;
    logic                    w_clr_wr;
    logic                    w_usr_wr;
    logic                    w_rd_acc;
    logic                    w_byp_hit;
    logic [ADDR_WIDTH-1:0]   w_wr_addr;
    logic [DATA_WIDTH-1:0]   w_wr_data;
    logic [DATA_WIDTH-1:0]   w_wr_bits;
    logic [DATA_WIDTH-1:0]   w_ram_q;
    logic [DATA_WIDTH-1:0]   w_rd_word;

    logic [DATA_WIDTH-1:0]   r_byp_mask;  // bits of the read result overridden by a same-address write
    logic [DATA_WIDTH-1:0]   r_byp_data;
    logic                    r_v1;

    // A sweep starts on request, or once automatically right after reset.
    assign w_start = clear_i | ((CLEAR_ON_RESET != 0) & r_armed);

    // Clear engine: IDLE -> CLEAR (DEPTH cycles) -> DONE (one cycle) -> IDLE.
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_armed <= 1'b1;
        end else begin
            r_armed <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (w_start) begin
                        r_state <= ST_CLEAR;
                        r_busy  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    r_cnt <= r_cnt + ADDR_WIDTH'(1);
                    if (r_cnt == LAST_ADDR) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Write-port arbitration: the sweep owns the port while busy. Nothing is
    // written on a reset edge so an aborted sweep stops cleanly.
    assign w_clr_wr  = reset_n_i & r_busy;
    assign w_usr_wr  = reset_n_i & we_i & ~r_busy;
    assign w_rd_acc  = reset_n_i & re_i & ~r_busy;
    assign w_wr_addr = r_busy ? r_cnt : write_addr_i;
    assign w_wr_data = r_busy ? CLEAR_VALUE : data_i;
    assign w_wr_bits = w_clr_wr ? {DATA_WIDTH{1'b1}} : (w_usr_wr ? wmask_i : '0);
    assign w_byp_hit = (BYPASS != 0) & w_usr_wr & (write_addr_i == read_addr_i);

    // One 1-bit-wide array per data bit, so the mask becomes a per-bit write
    // enable and no read-modify-write of the stored word is needed.
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : gen_bit
        logic r_mem [DEPTH];
        logic r_bit_q;

        // Masked write of this bit column.
        always_ff @(posedge clock_i) begin
            if (w_wr_bits[gi]) begin
                r_mem[w_wr_addr] <= w_wr_data[gi];
            end
        end

        // Registered read (old data on a same-address collision).
        always_ff @(posedge clock_i) begin
            if (!reset_n_i) begin
                r_bit_q <= 1'b0;
            end else if (w_rd_acc) begin
                r_bit_q <= r_mem[read_addr_i];
            end
        end

        assign w_ram_q[gi] = r_bit_q;
    end

    // Capture the colliding write so write-first results can be merged after the RAM.
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            r_byp_mask <= '0;
            r_byp_data <= '0;
            r_v1       <= 1'b0;
        end else begin
            r_v1 <= w_rd_acc;
            if (w_rd_acc) begin
                r_byp_mask <= w_byp_hit ? wmask_i : '0;
                r_byp_data <= data_i;
            end
        end
    end

    assign w_rd_word = (w_ram_q & ~r_byp_mask) | (r_byp_data & r_byp_mask);

    if (OUT_REG != 0) begin : gen_out_reg
        logic [DATA_WIDTH-1:0] r_q2;
        logic                  r_v2;

        // Extra output stage; reads in flight finish even if a sweep begins.
        always_ff @(posedge clock_i) begin
            if (!reset_n_i) begin
                r_q2 <= '0;
                r_v2 <= 1'b0;
            end else begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_q2 <= w_rd_word;
                end
            end
        end

        assign q_o       = r_q2;
        assign q_valid_o = r_v2;
    end else begin : gen_no_out_reg
        assign q_o       = w_rd_word;
        assign q_valid_o = r_v1;
    end

    assign busy_o = r_busy;
    assign done_o = r_done;

endmodule

// File: tb/tb_masked_dual_port_ram_clear.sv
// Bench for masked_dual_port_ram_clear. Two instances run side by side:
// dut0 = latency 1, write-first, auto-clear on reset;
// dut1 = latency 2, read-first, no auto-clear.
// Expected read results are pushed into per-DUT queues at issue time and a
// monitor pops and compares them (data and arrival cycle) on every q_valid_o.
module tb_masked_dual_port_ram_clear;

    localparam logic [6:0] CV = 7'h55;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst_n [2];
    logic       we_s  [2];
    logic       re_s  [2];
    logic       clr_s [2];
    logic [3:0] wa_s  [2];
    logic [3:0] ra_s  [2];
    logic [6:0] d_s   [2];
    logic [6:0] m_s   [2];
    logic [6:0] q_w   [2];
    logic       qv_w  [2];
    logic       busy_w[2];
    logic       done_w[2];

    masked_dual_port_ram_clear #(
        .DATA_WIDTH(7), .ADDR_WIDTH(4), .CLEAR_VALUE(CV),
        .OUT_REG(0), .BYPASS(1), .CLEAR_ON_RESET(1)
    ) dut0 (
        .clock_i(clk), .reset_n_i(rst_n[0]), .we_i(we_s[0]), .write_addr_i(wa_s[0]),
        .data_i(d_s[0]), .wmask_i(m_s[0]), .re_i(re_s[0]), .read_addr_i(ra_s[0]),
        .q_o(q_w[0]), .q_valid_o(qv_w[0]), .clear_i(clr_s[0]),
        .busy_o(busy_w[0]), .done_o(done_w[0])
    );

    masked_dual_port_ram_clear #(
        .DATA_WIDTH(7), .ADDR_WIDTH(4), .CLEAR_VALUE(CV),
        .OUT_REG(1), .BYPASS(0), .CLEAR_ON_RESET(0)
    ) dut1 (
        .clock_i(clk), .reset_n_i(rst_n[1]), .we_i(we_s[1]), .write_addr_i(wa_s[1]),
        .data_i(d_s[1]), .wmask_i(m_s[1]), .re_i(re_s[1]), .read_addr_i(ra_s[1]),
        .q_o(q_w[1]), .q_valid_o(qv_w[1]), .clear_i(clr_s[1]),
        .busy_o(busy_w[1]), .done_o(done_w[1])
    );

    typedef struct {
        logic [6:0] data;
        int         due;
    } exp_t;

    exp_t       sb0[$];
    exp_t       sb1[$];
    logic [6:0] mem_m [2][16];   // reference contents of each DUT
    int         checks   = 0;
    int         failures = 0;

    function automatic int lat_of(int k);
        return (k == 0) ? 1 : 2;
    endfunction

    function automatic bit byp_of(int k);
        return (k == 0);
    endfunction

    task automatic chk(string nm, int k, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s dut%0d actual=%0h expected=%0h (cycle %0d)", nm, k, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int k);
        we_s[k]  = 1'b0;
        re_s[k]  = 1'b0;
        clr_s[k] = 1'b0;
    endtask

    // Issue one cycle of user traffic on dut k and record what must come back.
    task automatic drive(int k, bit we, logic [3:0] wa, logic [6:0] d, logic [6:0] m,
                         bit re, logic [3:0] ra);
        logic [6:0] merged;
        exp_t       e;
        merged = (mem_m[k][wa] & ~m) | (d & m);
        if (re) begin
            e.data = (we && wa == ra && byp_of(k)) ? merged : mem_m[k][ra];
            e.due  = cyc + lat_of(k);
            if (k == 0) sb0.push_back(e);
            else        sb1.push_back(e);
        end
        if (we) mem_m[k][wa] = merged;
        we_s[k] = we;
        wa_s[k] = wa;
        d_s[k]  = d;
        m_s[k]  = m;
        re_s[k] = re;
        ra_s[k] = ra;
    endtask

    // Monitor: every valid result must match the oldest outstanding read.
    exp_t mon_e;
    bit   mon_got;
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            mon_got = 1'b0;
            if (qv_w[k] === 1'b1) begin
                if (k == 0 && sb0.size() > 0) begin mon_e = sb0.pop_front(); mon_got = 1'b1; end
                if (k == 1 && sb1.size() > 0) begin mon_e = sb1.pop_front(); mon_got = 1'b1; end
                if (!mon_got) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid dut%0d q=%0h (cycle %0d)", k, q_w[k], cyc);
                end else begin
                    $display("read dut%0d cycle %0d q=%0h expected=%0h", k, cyc, q_w[k], mon_e.data);
                    chk("read_data", k, int'(q_w[k]), int'(mon_e.data));
                    chk("read_latency", k, cyc, mon_e.due);
                end
            end else begin
                if (k == 0 && sb0.size() > 0 && sb0[0].due <= cyc) begin
                    mon_e = sb0.pop_front();
                    chk("missing_valid", k, 0, 1);
                end
                if (k == 1 && sb1.size() > 0 && sb1[0].due <= cyc) begin
                    mon_e = sb1.pop_front();
                    chk("missing_valid", k, 0, 1);
                end
            end
        end
    end

    int busy_cnt, done_cnt, done_after_busy, other_act;
    bit prev_busy;

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0;
            idle(k);
            wa_s[k] = '0; ra_s[k] = '0; d_s[k] = '0; m_s[k] = '0;
        end

        // Reset values.
        repeat (3) tick();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset_q", k, int'(q_w[k]), 0);
            chk("reset_q_valid", k, int'(qv_w[k]), 0);
            chk("reset_busy", k, int'(busy_w[k]), 0);
            chk("reset_done", k, int'(done_w[k]), 0);
        end
        tick();
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        // Auto-clear after reset on dut0; dut1 must stay idle.
        busy_cnt = 0; done_cnt = 0; done_after_busy = 0; other_act = 0; prev_busy = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy_w[0]) busy_cnt++;
            if (done_w[0]) begin
                done_cnt++;
                if (prev_busy && !busy_w[0]) done_after_busy++;
            end
            prev_busy = busy_w[0];
            if (busy_w[1] || done_w[1]) other_act++;
        end
        chk("auto_clear_busy_cycles", 0, busy_cnt, 16);
        chk("auto_clear_done_pulses", 0, done_cnt, 1);
        chk("auto_clear_done_follows_busy", 0, done_after_busy, 1);
        chk("no_auto_clear", 1, other_act, 0);
        for (int a = 0; a < 16; a++) mem_m[0][a] = CV;
        tick();
        for (int a = 0; a < 16; a++) begin
            drive(0, 1'b0, 4'h0, 7'h00, 7'h00, 1'b1, 4'(a));
            tick();
        end
        idle(0);
        repeat (4) tick();

        // Clear on dut1 with writes, reads and clear requests issued while busy.
        clr_s[1] = 1'b1;
        tick();
        clr_s[1] = 1'b0;
        busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy_w[1]) busy_cnt++;
            if (done_w[1]) done_cnt++;
            if (i >= 3 && i <= 5) begin
                we_s[1] = 1'b1; wa_s[1] = 4'd2; d_s[1] = 7'h0A; m_s[1] = 7'h7F;
                re_s[1] = 1'b1; ra_s[1] = 4'd2; clr_s[1] = 1'b1;
            end else begin
                idle(1);
            end
        end
        chk("blocked_clear_busy_cycles", 1, busy_cnt, 16);
        chk("blocked_clear_done_pulses", 1, done_cnt, 1);
        for (int a = 0; a < 16; a++) mem_m[1][a] = CV;
        tick();
        drive(1, 1'b0, 4'h0, 7'h00, 7'h00, 1'b1, 4'd2);
        tick();
        idle(1);
        repeat (4) tick();

        // Masked write, read-during-write, back-to-back reads on both DUTs.
        for (int k = 0; k < 2; k++) drive(k, 1'b1, 4'd3, 7'h7F, 7'h7F, 1'b0, 4'd0);
        tick();
        for (int k = 0; k < 2; k++) drive(k, 1'b1, 4'd3, 7'h00, 7'h0F, 1'b0, 4'd0);
        tick();
        for (int k = 0; k < 2; k++) drive(k, 1'b0, 4'd0, 7'h00, 7'h00, 1'b1, 4'd3);
        tick();
        for (int k = 0; k < 2; k++) drive(k, 1'b1, 4'd5, 7'h11, 7'h7F, 1'b0, 4'd0);
        tick();
        for (int k = 0; k < 2; k++) drive(k, 1'b1, 4'd5, 7'h22, 7'h7F, 1'b1, 4'd5);
        tick();
        for (int k = 0; k < 2; k++) drive(k, 1'b0, 4'd0, 7'h00, 7'h00, 1'b1, 4'd5);
        tick();
        for (int a = 0; a < 3; a++) begin
            for (int k = 0; k < 2; k++) drive(k, 1'b0, 4'd0, 7'h00, 7'h00, 1'b1, 4'(a));
            tick();
        end
        for (int k = 0; k < 2; k++) idle(k);
        repeat (4) tick();

        // Randomized traffic against the reference model.
        for (int n = 0; n < 300; n++) begin
            for (int k = 0; k < 2; k++) begin
                drive(k, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                      7'($urandom), 7'($urandom), 1'($urandom_range(0, 1)),
                      4'($urandom_range(0, 15)));
            end
            tick();
        end
        for (int k = 0; k < 2; k++) idle(k);
        repeat (4) tick();

        // Reset in the middle of a sweep on dut1.
        for (int a = 0; a < 16; a++) begin
            drive(1, 1'b1, 4'(a), 7'h01, 7'h7F, 1'b0, 4'd0);
            tick();
        end
        idle(1);
        clr_s[1] = 1'b1;
        tick();
        clr_s[1] = 1'b0;
        @(negedge clk);
        chk("sweep_started", 1, int'(busy_w[1]), 1);
        repeat (6) tick();
        rst_n[1] = 1'b0;
        tick();
        @(negedge clk);
        chk("abort_busy", 1, int'(busy_w[1]), 0);
        chk("abort_done", 1, int'(done_w[1]), 0);
        tick();
        rst_n[1] = 1'b1;
        other_act = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy_w[1] || done_w[1]) other_act++;
        end
        chk("abort_no_done", 1, other_act, 0);
        for (int a = 0; a < 6; a++) mem_m[1][a] = CV;
        tick();
        for (int a = 0; a < 16; a++) begin
            drive(1, 1'b0, 4'h0, 7'h00, 7'h00, 1'b1, 4'(a));
            tick();
        end
        idle(1);
        repeat (6) tick();

        chk("scoreboard_drained", 0, sb0.size(), 0);
        chk("scoreboard_drained", 1, sb1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
